// File: rtl/tube_scan_decoder.sv
// rtl/tube_scan_decoder.sv - de-ghosting decoder for the 11-bit multiplexed tube bus
module tube_scan_decoder #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] tube_11bit,
    output logic [6:0]  dec_hour,
    output logic [6:0]  dec_min,
    output logic [6:0]  dec_sec,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        signal_lost
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [10:0]   s_q;
    logic [10:0]   p_q;
    logic [HW-1:0] hold_cnt;
    logic [5:0]    seen;
    logic [5:0]    err;
    logic [5:0]    seen_n;
    logic [5:0]    err_n;
    logic [3:0]    digit_q [6];
    logic [TW-1:0] to_cnt;

    logic [2:0]    sel;
    logic          sel_ok;
    logic          same;
    logic          accept;
    logic          frame_done;
    logic          timeout_hit;
    logic [3:0]    dig;
    logic          bad;

    assign sel         = s_q[10:8];
    assign sel_ok      = (sel < 3'd6);
    assign same        = (s_q == p_q);
    // Hold count is registered, so acceptance fires on the edge it would reach HOLD_CYCLES.
    assign accept      = sel_ok && same && (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign frame_done  = (seen == 6'h3f);
    assign timeout_hit = !accept && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        dig = 4'd0;
        bad = 1'b0;
        case (s_q[6:0])
            7'h3f:   dig = 4'd0;
            7'h06:   dig = 4'd1;
            7'h5b:   dig = 4'd2;
            7'h4f:   dig = 4'd3;
            7'h66:   dig = 4'd4;
            7'h6d:   dig = 4'd5;
            7'h7d:   dig = 4'd6;
            7'h07:   dig = 4'd7;
            7'h7f:   dig = 4'd8;
            7'h6f:   dig = 4'd9;
            7'h00:   dig = 4'd0;
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        seen_n = seen;
        err_n  = err;
        if (frame_done || timeout_hit) begin
            seen_n = 6'd0;
            err_n  = 6'd0;
        end
        for (int i = 0; i < 6; i++) begin
            if (accept && sel == 3'(i)) begin
                seen_n[i] = 1'b1;
                err_n[i]  = bad;
            end
        end
    end

    function automatic logic [6:0] to_bin(input logic [3:0] tens, input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= 11'd0;
            p_q         <= 11'd0;
            hold_cnt    <= '0;
            seen        <= 6'd0;
            err         <= 6'd0;
            to_cnt      <= '0;
            dec_hour    <= 7'd0;
            dec_min     <= 7'd0;
            dec_sec     <= 7'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            signal_lost <= 1'b0;
            for (int i = 0; i < 6; i++) digit_q[i] <= 4'd0;
        end else begin
            s_q <= tube_11bit;
            p_q <= s_q;

            if (!sel_ok)
                hold_cnt <= '0;
            else if (!same)
                hold_cnt <= HW'(1);
            else if (hold_cnt != HW'(HOLD_CYCLES))
                hold_cnt <= hold_cnt + HW'(1);

            for (int i = 0; i < 6; i++) begin
                if (accept && sel == 3'(i)) digit_q[i] <= dig;
            end
            seen <= seen_n;
            err  <= err_n;

            frame_valid <= frame_done;
            frame_err   <= frame_done && (|err);
            if (frame_done) begin
                dec_hour <= to_bin(digit_q[0], digit_q[1]);
                dec_min  <= to_bin(digit_q[2], digit_q[3]);
                dec_sec  <= to_bin(digit_q[4], digit_q[5]);
            end

            if (accept) begin
                to_cnt      <= '0;
                signal_lost <= 1'b0;
            end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
                to_cnt <= to_cnt + TW'(1);
                if (timeout_hit) signal_lost <= 1'b1;
            end
        end
    end

endmodule
